// File: rtl/reg_file_sb.sv
// Parametrised register file with N combinational read ports, write-to-read bypass,
// optional hardwired-zero register and a pending-write scoreboard for RAW stalls.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt,
  output logic                     pend_full
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(DEPTH - ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic              wr_ok, iss_ok, set_new, clr_old;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    wr_ok   = wr_en && !is_zero(wr_addr);
    iss_ok  = iss_en && !is_zero(iss_addr);
    set_new = iss_ok && !pend[iss_addr];
    // a re-issue to the register being written keeps it pending, so no decrement
    clr_old = wr_ok && pend[wr_addr] && !(iss_ok && (iss_addr == wr_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // issue assignment follows the write clear so issue wins on a shared address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (wr_ok)  pend[wr_addr]  <= 1'b0;
      if (iss_ok) pend[iss_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      pend_cnt <= pend_cnt + (ADDR_W + 1)'(set_new) - (ADDR_W + 1)'(clr_old);
    end
  end

  assign pend_full = (pend_cnt == MAX_CNT);

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
      if (is_zero(ra[k])) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if (rst_n && wr_en && (wr_addr == ra[k])) begin
        // bypass is gated by reset so reads stay zero while the array is held clear
        rd_data[k*DATA_W +: DATA_W] = wr_data;
        rd_busy[k]                  = 1'b0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem[ra[k]];
        rd_busy[k]                  = pend[ra[k]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en, iss_en;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic [5:0]  pend_cnt;
  logic        pend_full;

  logic [4:0]  z_rd_addr;
  logic [31:0] z_rd_data;
  logic [0:0]  z_rd_busy;
  logic        z_wr_en, z_iss_en;
  logic [4:0]  z_wr_addr, z_iss_addr;
  logic [31:0] z_wr_data;
  logic [5:0]  z_pend_cnt;
  logic        z_pend_full;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .pend_cnt(pend_cnt), .pend_full(pend_full));

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .iss_en(z_iss_en),
    .iss_addr(z_iss_addr), .pend_cnt(z_pend_cnt), .pend_full(z_pend_full));

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rst_n && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (rst_n && wr_en && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_pend[i];
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
  endtask

  // advance one clock; update the model from the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (wr_en && wr_addr != 0) begin m_mem[wr_addr] = wr_data; m_pend[wr_addr] = 0; end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; z_wr_en = 0; z_iss_en = 0;
  endtask

  task automatic test_reset();
    vectors++;
    if (pend_cnt !== 6'd0 || pend_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cnt got cnt=%0d full=%b exp cnt=0 full=0", pend_cnt, pend_full);
    end
    rd_addr = {5'd9, 5'd1}; #1;
    vectors++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_rd got data=%h busy=%b exp 0/0", rd_data, rd_busy);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5'd1; wr_data = 32'h0C70F26F; tick();
    wr_addr = 5'd2; wr_data = 32'h0C70F26E; tick();
    idle(); rd_addr = {5'd2, 5'd1}; #1;
    vectors++;
    if (rd_data[31:0] !== 32'h0C70F26F) begin
      miscompares++; $display("FAIL wr_rd_p0 got %h exp 0c70f26f", rd_data[31:0]);
    end
    vectors++;
    if (rd_data[63:32] !== 32'h0C70F26E) begin
      miscompares++; $display("FAIL wr_rd_p1 got %h exp 0c70f26e", rd_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; rd_addr = {5'd1, 5'd3}; #1;
    vectors++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL bypass got %h exp deadbeef", rd_data[31:0]);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL bypass_array got %h exp deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    int c0;
    c0 = exp_cnt();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
    rd_addr = {5'd0, 5'd0};
    z_wr_en = 1; z_wr_addr = 0; z_wr_data = 32'hFFFFFFFF; z_rd_addr = 0; #1;
    vectors++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL zero_same_cycle got %h busy=%b exp 0/0", rd_data[31:0], rd_busy[0]);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL zero_after got %h busy=%b exp 0/0", rd_data[31:0], rd_busy[0]);
    end
    vectors++;
    if (pend_cnt !== 6'(c0)) begin
      miscompares++; $display("FAIL zero_cnt got %0d exp %0d", pend_cnt, c0);
    end
    vectors++;
    if (z_rd_data !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL nz_r0 got %h exp ffffffff", z_rd_data);
    end
    z_iss_en = 1; z_iss_addr = 0; @(posedge clk); #1; idle(); #1;
    vectors++;
    if (z_pend_cnt !== 6'd1 || z_rd_busy !== 1'b1) begin
      miscompares++; $display("FAIL nz_r0_pend got cnt=%0d busy=%b exp 1/1", z_pend_cnt, z_rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_addr = 5'd5; rd_addr = {5'd0, 5'd5}; #1;
    vectors++;
    if (rd_busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL sb_issue_same_cycle got busy=%b exp 0", rd_busy[0]);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
      miscompares++; $display("FAIL sb_issue got busy=%b cnt=%0d exp 1/1", rd_busy[0], pend_cnt);
    end
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'h5555AAAA; #1;
    vectors++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h5555AAAA) begin
      miscompares++; $display("FAIL sb_wb_bypass got busy=%b data=%h exp 0/5555aaaa", rd_busy[0], rd_data[31:0]);
    end
    tick(); idle(); #1;
    vectors++;
    if (rd_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
      miscompares++; $display("FAIL sb_wb got busy=%b cnt=%0d exp 0/0", rd_busy[0], pend_cnt);
    end
    iss_en = 1; iss_addr = 5'd5; tick();
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'h12345678; iss_en = 1; iss_addr = 5'd5;
    tick(); idle(); #1;
    vectors++;
    if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1 || rd_data[31:0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL sb_wr_iss got busy=%b cnt=%0d data=%h exp 1/1/12345678", rd_busy[0], pend_cnt, rd_data[31:0]);
    end
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'h0; tick(); idle();
  endtask

  task automatic test_full();
    for (int r = 1; r < 32; r++) begin iss_en = 1; iss_addr = 5'(r); tick(); end
    idle(); #1;
    vectors++;
    if (pend_cnt !== 6'd31 || pend_full !== 1'b1) begin
      miscompares++; $display("FAIL full got cnt=%0d full=%b exp 31/1", pend_cnt, pend_full);
    end
    iss_en = 1; iss_addr = 5'd17; tick(); idle(); #1;
    vectors++;
    if (pend_cnt !== 6'd31) begin
      miscompares++; $display("FAIL full_reissue got cnt=%0d exp 31", pend_cnt);
    end
    wr_en = 1; wr_addr = 5'd7; wr_data = 32'h77; tick(); idle(); #1;
    vectors++;
    if (pend_cnt !== 6'd30 || pend_full !== 1'b0) begin
      miscompares++; $display("FAIL full_wb got cnt=%0d full=%b exp 30/0", pend_cnt, pend_full);
    end
  endtask

  task automatic test_random(input int n);
    logic [4:0] a;
    int e;
    for (int it = 0; it < n; it++) begin
      wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
      iss_en = 1'($urandom); iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      for (int k = 0; k < 2; k++)
        rd_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        vectors++;
        if (rd_data[k*32 +: 32] !== exp_data(a) || rd_busy[k] !== exp_busy(a)) begin
          miscompares++;
          $display("FAIL rand_rd it=%0d port=%0d addr=%0d got %h/%b exp %h/%b",
                   it, k, a, rd_data[k*32 +: 32], rd_busy[k], exp_data(a), exp_busy(a));
        end
      end
      tick();
      e = exp_cnt();
      vectors++;
      if (pend_cnt !== 6'(e) || pend_full !== (e == 31)) begin
        miscompares++;
        $display("FAIL rand_cnt it=%0d got %0d/%b exp %0d/%b", it, pend_cnt, pend_full, e, e == 31);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D; iss_en = 1; iss_addr = 5'd10; tick();
    wr_addr = 5'd11; wr_data = 32'hA5A5A5A5; iss_en = 0; rd_addr = {5'd11, 5'd9};
    #2 rst_n = 0; #1;
    vectors++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      miscompares++; $display("FAIL async_rst_rd got %h busy=%b exp 0/0", rd_data, rd_busy);
    end
    vectors++;
    if (pend_cnt !== 6'd0 || pend_full !== 1'b0 || z_pend_cnt !== 6'd0) begin
      miscompares++; $display("FAIL async_rst_cnt got %0d/%b nz=%0d exp 0/0/0", pend_cnt, pend_full, z_pend_cnt);
    end
    tick(); model_reset(); rd_addr = {5'd11, 5'd10}; idle(); #1;
    vectors++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      miscompares++; $display("FAIL rst_ignores_wr got %h busy=%b exp 0/0", rd_data, rd_busy);
    end
    #3 rst_n = 1;
    tick();
  endtask

  initial begin
    rst_n = 0; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    z_rd_addr = '0; z_wr_addr = '0; z_wr_data = '0; z_iss_addr = '0;
    idle(); model_reset();
    #12 rst_n = 1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_full();
    test_random(400);
    test_async_reset();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
